// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and data ports.
// Data has priority, with a bounded streak so that a pending fetch cannot starve.
module unified_mem_arbiter #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned MAX_DFIRST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        grant_if,
    output logic        grant_d
);

    localparam int unsigned WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned DSTR_W = ($clog2(MAX_DFIRST + 1) > 3) ? $clog2(MAX_DFIRST + 1) : 3;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(LAT - 1);
    localparam logic [DSTR_W-1:0] DSTR_MAX  = DSTR_W'(MAX_DFIRST);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [DSTR_W-1:0] dstreak_q, dstreak_d;
    logic              grant_if_q, grant_if_d;
    logic              grant_d_q, grant_d_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              pick_d;
    logic              pick_if;
    logic [DSTR_W-1:0] dstreak_inc;

    // Data wins unless fetch is waiting and data already had its full streak.
    assign pick_d  = d_req && (!if_req || (dstreak_q != DSTR_MAX));
    assign pick_if = if_req && !pick_d;

    assign dstreak_inc = (dstreak_q == DSTR_MAX) ? DSTR_MAX : dstreak_q + DSTR_W'(1);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        dstreak_d   = dstreak_q;
        grant_if_d  = grant_if_q;
        grant_d_d   = grant_d_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    grant_d_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    dstreak_d   = if_req ? dstreak_inc : '0;
                    state_d     = StAccess;
                end else if (pick_if) begin
                    grant_if_d  = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    dstreak_d   = '0;
                    state_d     = StAccess;
                end
            end

            StAccess: begin
                if (mem_we_q) begin
                    state_d = StResp;
                end else begin
                    wcnt_d  = WCNT_INIT;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (wcnt_q == '0) begin
                    if (grant_if_q) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end

            StResp: begin
                grant_if_d = 1'b0;
                grant_d_d  = 1'b0;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            wcnt_q      <= '0;
            dstreak_q   <= '0;
            grant_if_q  <= 1'b0;
            grant_d_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            dstreak_q   <= dstreak_d;
            grant_if_q  <= grant_if_d;
            grant_d_q   <= grant_d_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == StAccess);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_ack    = (state_q == StResp) && grant_if_q;
    assign d_ack     = (state_q == StResp) && grant_d_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign busy      = (state_q != StIdle);
    assign grant_if  = grant_if_q;
    assign grant_d   = grant_d_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a LAT=2 instance against a cycle-arithmetic transaction model,
// plus a LAT=1 instance for back-to-back load spacing.
module tb_unified_mem_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int MAXD = 4;

    logic clk = 1'b0;
    logic reset;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, busy, grant_if, grant_d;
    logic [31:0] if_rdata, d_rdata;

    logic        d_req1, d_we1;
    logic [31:0] d_addr1, d_wdata1;
    logic        if_ack1, d_ack1, busy1, grant_if1, grant_d1;
    logic [31:0] if_rdata1, d_rdata1;

    logic [1:0]       mem_en, mem_we;
    logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

    unified_mem_arbiter #(.LAT(LAT0), .MAX_DFIRST(MAXD)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy), .grant_if(grant_if), .grant_d(grant_d)
    );

    unified_mem_arbiter #(.LAT(LAT1), .MAX_DFIRST(MAXD)) u1 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy1), .grant_if(grant_if1), .grant_d(grant_d1)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] init_word(int idx);
        logic [31:0] w;
        w = 32'(idx);
        return (idx == 4) ? 32'h0051_0113 : ((w * 32'h9E37_79B9) ^ 32'h1357_9BDF);
    endfunction

    // Memory environment: writes land at the edge closing mem_en; reads valid LAT cycles later.
    logic [31:0] env_mem [2][256];
    bit          env_wr  [2][256];
    bit          pend    [2];
    int          pend_cnt[2];
    logic [7:0]  pend_idx[2];
    logic [31:0] junk;

    always @(posedge clk) begin
        junk <= $urandom;
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i] === 1'b1 && mem_we[i] === 1'b1) begin
                env_mem[i][mem_addr[i][9:2]] <= mem_wdata[i];
                env_wr[i][mem_addr[i][9:2]]  <= 1'b1;
            end
            if (mem_en[i] === 1'b1 && mem_we[i] === 1'b0) begin
                pend[i]     <= 1'b1;
                pend_cnt[i] <= ((i == 0) ? LAT0 : LAT1) - 1;
                pend_idx[i] <= mem_addr[i][9:2];
            end else if (pend[i]) begin
                if (pend_cnt[i] == 0) pend[i] <= 1'b0;
                else pend_cnt[i] <= pend_cnt[i] - 1;
            end
        end
    end

    always_comb begin
        mem_rdata[0] = junk;
        mem_rdata[1] = ~junk;
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && pend_cnt[i] == 0) begin
                mem_rdata[i] = env_wr[i][pend_idx[i]] ? env_mem[i][pend_idx[i]]
                                                      : init_word(int'(pend_idx[i]));
            end
        end
    end

    // Reference model: transaction-level view with cycle arithmetic.
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    bit          t_act, t_if, t_we;
    logic [31:0] t_addr, t_wdata;
    int          t_k, t_ack;
    int          streak;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    logic [31:0] exp_mem [256];
    bit          exp_wr  [256];
    int          p_if, p_d, p_st;
    bit          prev_if_req;
    int          dwait;
    bit          rec_order;
    bit          order_q[$];
    bit          exp_order[10];
    int          last_en_cyc, last_if_ack_cyc, last_d_ack_cyc, d_ack_cnt;
    logic        last_en_we;

    function automatic logic [31:0] exp_rd(logic [7:0] idx);
        return exp_wr[idx] ? exp_mem[idx] : init_word(int'(idx));
    endfunction

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        bit in_win, exp_en, exp_ifa, exp_da;
        in_win  = t_act && n > t_k && n <= t_ack;
        exp_en  = t_act && n == t_k + 1;
        exp_ifa = t_act && t_if && n == t_ack;
        exp_da  = t_act && !t_if && n == t_ack;
        if (exp_en && t_we) begin
            exp_mem[t_addr[9:2]] = t_wdata;
            exp_wr[t_addr[9:2]]  = 1'b1;
        end
        if (exp_ifa) exp_if_rdata = exp_rd(t_addr[9:2]);
        if (exp_da && !t_we) exp_d_rdata = exp_rd(t_addr[9:2]);

        check1("busy", busy, in_win);
        check1("grant_if", grant_if, in_win && t_if);
        check1("grant_d", grant_d, in_win && !t_if);
        check1("mem_en", mem_en[0], exp_en);
        if (exp_en) begin
            check32("mem_addr", mem_addr[0], t_addr);
            check1("mem_we", mem_we[0], t_we);
            if (t_we) check32("mem_wdata", mem_wdata[0], t_wdata);
        end
        check1("if_ack", if_ack, exp_ifa);
        check1("d_ack", d_ack, exp_da);
        check32("if_rdata", if_rdata, exp_if_rdata);
        check32("d_rdata", d_rdata, exp_d_rdata);

        if (mem_en[0] === 1'b1) begin
            last_en_cyc = n;
            last_en_we  = mem_we[0];
            if (rec_order) order_q.push_back(grant_if === 1'b1);
            if (grant_d === 1'b1 && prev_if_req) begin
                dwait++;
                check1("fetch_starved", dwait > MAXD, 1'b0);
            end
        end
        if (if_ack === 1'b1) begin
            last_if_ack_cyc = n;
            dwait = 0;
        end
        if (d_ack === 1'b1) begin
            last_d_ack_cyc = n;
            d_ack_cnt++;
        end

        if (exp_ifa) if_req = 1'b0;
        if (exp_da) d_req = 1'b0;
        if (!if_req && $urandom_range(99) < p_if) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req && $urandom_range(99) < p_d) begin
            d_req   = 1'b1;
            d_we    = $urandom_range(99) < p_st;
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
        end

        if (!t_act || n > t_ack) begin
            if (d_req && (!if_req || streak != MAXD)) begin
                t_act = 1'b1; t_if = 1'b0; t_we = d_we; t_addr = d_addr; t_wdata = d_wdata;
                t_k = n; t_ack = n + (t_we ? 2 : LAT0 + 2);
                streak = if_req ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
            end else if (if_req) begin
                t_act = 1'b1; t_if = 1'b1; t_we = 1'b0; t_addr = if_addr;
                t_k = n; t_ack = n + LAT0 + 2;
                streak = 0;
            end
        end
        prev_if_req = if_req;
        @(negedge clk);
        n++;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        d_req1 = 1'b0;
        t_act = 1'b0;
        streak = 0;
        exp_if_rdata = '0;
        exp_d_rdata = '0;
        dwait = 0;
        prev_if_req = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            n++;
            check32("rst_ctl", {25'b0, if_ack, d_ack, mem_en[0], mem_we[0], busy, grant_if, grant_d},
                    32'h0);
            check32("rst_if_rdata", if_rdata, 32'h0);
            check32("rst_d_rdata", d_rdata, 32'h0);
            check32("rst_mem_addr", mem_addr[0], 32'h0);
            check32("rst_mem_wdata", mem_wdata[0], 32'h0);
        end
        reset = 1'b1;
    endtask

    initial begin
        int k;
        int op, cyc, prev_ack;
        logic [31:0] a1[4];
        logic [31:0] w1[4];

        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
        p_if = 0; p_d = 0; p_st = 0; rec_order = 0;
        last_en_cyc = -1; last_if_ack_cyc = -1; last_d_ack_cyc = -1; d_ack_cnt = 0;
        last_en_we = 1'bx;
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        do_reset(5);
        repeat (3) step();

        // Single fetch from 0x10.
        if_req = 1'b1; if_addr = 32'h10; k = n;
        repeat (8) step();
        check_i("fetch_en_cycle", last_en_cyc, k + 1);
        check1("fetch_we", last_en_we, 1'b0);
        check_i("fetch_ack_cycle", last_if_ack_cyc, k + 4);
        check32("fetch_word", if_rdata, 32'h0051_0113);

        // Store 25 to 0x64, then read it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'd25; k = n;
        repeat (6) step();
        check_i("store_en_cycle", last_en_cyc, k + 1);
        check1("store_we", last_en_we, 1'b1);
        check_i("store_ack_cycle", last_d_ack_cyc, k + 2);
        check32("store_d_rdata", d_rdata, 32'h0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h64; k = n;
        repeat (7) step();
        check_i("load_ack_cycle", last_d_ack_cyc, k + 4);
        check32("load_word", d_rdata, 32'd25);

        // Both ports requesting continuously.
        order_q.delete();
        rec_order = 1'b1; p_if = 100; p_d = 100; p_st = 50;
        for (int i = 0; i < 200 && order_q.size() < 10; i++) step();
        rec_order = 1'b0; p_if = 0; p_d = 0;
        check_i("order_len", order_q.size(), 10);
        for (int i = 0; i < 10 && i < order_q.size(); i++) begin
            check1($sformatf("order%0d", i), order_q[i], exp_order[i]);
        end
        repeat (20) step();

        // Random traffic.
        p_if = 35; p_d = 45; p_st = 40;
        repeat (1500) step();
        p_if = 0; p_d = 0;
        repeat (20) step();

        // Reset during the WAIT of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h64;
        step();
        step();
        check1("mid_busy", busy, 1'b1);
        do_reset(1);
        d_ack_cnt = 0;
        repeat (10) step();
        check_i("abandoned_ack", d_ack_cnt, 0);
        check32("abandoned_rdata", d_rdata, 32'h0);

        // LAT=1 instance: four stores then four loads, request re-presented right after each ack.
        for (int i = 0; i < 4; i++) begin
            a1[i] = ($urandom & 32'hFFFF_FC00) | 32'(32'h100 + 12 * i);
            w1[i] = $urandom;
        end
        op = 0; cyc = 0; prev_ack = -1;
        d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = a1[0]; d_wdata1 = w1[0];
        while (op < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (d_ack1 === 1'b1) begin
                if (op >= 4) check32($sformatf("lat1_load%0d", op - 4), d_rdata1, w1[op - 4]);
                if (op > 0) check_i($sformatf("lat1_gap%0d", op), cyc - prev_ack, (op >= 4) ? 4 : 3);
                prev_ack = cyc;
                op++;
                if (op < 8) begin
                    d_we1 = (op < 4);
                    d_addr1 = a1[op % 4];
                    d_wdata1 = w1[op % 4];
                end else begin
                    d_req1 = 1'b0;
                end
            end
        end
        check_i("lat1_ops", op, 8);
        d_req1 = 1'b0;
        repeat (2) @(negedge clk);
        check32("lat1_idle", {27'b0, busy1, grant_if1, grant_d1, if_ack1, d_ack1}, 32'h0);
        check32("lat1_if_rdata", if_rdata1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
